// File: rtl/gfx_pkg.sv
// gfx_pkg: shared definitions for the CPU-side VRAM/palette write path.
//   region_e   : target RAM of a store (VRAM or palette)
//   size_e     : store width (byte or halfword)
//   VRAM_*     : VRAM size and mirror base, byte addresses
//   BG_LIMIT_* : end of the BG area; byte stores at or above it are ignored
//   wr_entry_t : one translated write as held in the write buffer
package gfx_pkg;

  typedef enum logic {
    REGION_VRAM = 1'b0,
    REGION_PAL  = 1'b1
  } region_e;

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_HALF = 1'b1
  } size_e;

  localparam logic [16:0] VRAM_BYTES       = 17'h18000;
  localparam logic [16:0] VRAM_MIRROR_BASE = 17'h10000;
  localparam logic [16:0] BG_LIMIT_TILE    = 17'h10000;
  localparam logic [16:0] BG_LIMIT_BMP     = 17'h14000;

  typedef struct packed {
    region_e     region;
    logic [15:0] waddr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_entry_t;

  // Bitmap modes (3..5, and the unused 6/7) extend the BG area into the
  // first 16 KiB of what is otherwise OBJ tile memory.
  function automatic logic [16:0] bg_limit(input logic [2:0] bg_mode);
    return (bg_mode >= 3'd3) ? BG_LIMIT_BMP : BG_LIMIT_TILE;
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// vram_writer_if: CPU/DMA store bus into the VRAM writer.
//   cpu_req    : store request, accepted when cpu_req && cpu_ready
//   cpu_ready  : writer can take a store this cycle
//   cpu_region : 0 = VRAM, 1 = palette
//   cpu_addr   : byte address within the region
//   cpu_size   : 0 = byte, 1 = halfword
//   cpu_wdata  : store data (byte stores use [7:0])
// Modports: master = CPU/DMA side, slave = vram_writer.
interface vram_writer_if;

  logic        cpu_req;
  logic        cpu_ready;
  logic        cpu_region;
  logic [16:0] cpu_addr;
  logic        cpu_size;
  logic [15:0] cpu_wdata;

  modport master (
    output cpu_req,
    output cpu_region,
    output cpu_addr,
    output cpu_size,
    output cpu_wdata,
    input  cpu_ready
  );

  modport slave (
    input  cpu_req,
    input  cpu_region,
    input  cpu_addr,
    input  cpu_size,
    input  cpu_wdata,
    output cpu_ready
  );

endinterface

// File: rtl/wr_fifo.sv
// wr_fifo: synchronous write buffer of translated store entries.
//   FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push/din : enqueue an entry (ignored when full)
//   pop/dout : dequeue the head entry; dout shows the head combinationally
//   full     : FIFO_DEPTH entries held
//   empty    : no entries held
module wr_fifo
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only; a reset invalidates it through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vram_writer.sv
// vram_writer: buffers CPU/DMA stores to VRAM and palette RAM and drains them
// into the shared RAM port only in cycles where the display is not reading.
// Byte stores are widened to halfword writes with the byte duplicated; byte
// stores into the OBJ area of VRAM are accepted but discarded.
//
// Configuration macro: VRAM_MIRROR_EN
//   defined   : VRAM 0x18000-0x1FFFF folds onto 0x10000-0x17FFF
//   undefined : VRAM stores at or above 0x18000 are accepted and discarded
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cpu        : store bus (vram_writer_if.slave)
//   dispcnt    : DISPCNT, [2:0] = BG mode, sampled when a store is accepted
//   disp_busy  : display owns the RAM port this cycle
//   vram_we    : one-cycle VRAM write strobe
//   pal_we     : one-cycle palette write strobe
//   mem_waddr  : halfword write address (palette uses [7:0])
//   mem_wdata  : write data
//   mem_be     : byte enables {hi,lo}
//   fifo_empty : no stores pending
module vram_writer
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  vram_writer_if.slave       cpu,
  input  logic [15:0]        dispcnt,
  input  logic               disp_busy,
  output logic               vram_we,
  output logic               pal_we,
  output logic [15:0]        mem_waddr,
  output logic [15:0]        mem_wdata,
  output logic [1:0]         mem_be,
  output logic               fifo_empty
);

  logic        accept_p0;
  logic        drop_p0;
  logic        push_p0;
  logic [16:0] vaddr_p0;
  wr_entry_t   entry_p0;
  wr_entry_t   head_p1;
  logic        pop_p1;
  logic        full;
  logic        empty;
  logic        unused_dispcnt;

  assign unused_dispcnt = ^dispcnt[15:3];

  // ---- stage p0: acceptance and store translation ----
  // No bypass: a full buffer refuses even if it is popping this cycle.
  assign cpu.cpu_ready = !full;
  assign accept_p0     = cpu.cpu_req && cpu.cpu_ready;
  assign push_p0       = accept_p0 && !drop_p0;

  always_comb begin
    vaddr_p0 = cpu.cpu_addr;
    drop_p0  = 1'b0;

    // Mirror folding happens before the OBJ-area check so that a folded
    // byte store is judged against the BG limit like any other.
    if (region_e'(cpu.cpu_region) == REGION_VRAM && cpu.cpu_addr >= VRAM_BYTES) begin
`ifdef VRAM_MIRROR_EN
      vaddr_p0 = cpu.cpu_addr - (VRAM_BYTES - VRAM_MIRROR_BASE);
`else
      drop_p0  = 1'b1;
`endif
    end

    if (region_e'(cpu.cpu_region) == REGION_VRAM &&
        size_e'(cpu.cpu_size) == SIZE_BYTE &&
        vaddr_p0 >= bg_limit(dispcnt[2:0])) begin
      drop_p0 = 1'b1;
    end

    entry_p0.region = region_e'(cpu.cpu_region);
    entry_p0.be     = 2'b11;
    entry_p0.waddr  = (region_e'(cpu.cpu_region) == REGION_PAL) ?
                      {8'h00, cpu.cpu_addr[8:1]} : vaddr_p0[16:1];
    entry_p0.data   = (size_e'(cpu.cpu_size) == SIZE_BYTE) ?
                      {2{cpu.cpu_wdata[7:0]}} : cpu.cpu_wdata;
  end

  wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p0),
    .din   (entry_p0),
    .pop   (pop_p1),
    .dout  (head_p1),
    .full  (full),
    .empty (empty)
  );

  assign fifo_empty = empty;

  // ---- stage p1: drain into the registered RAM-port outputs ----
  assign pop_p1 = !empty && !disp_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_we   <= 1'b0;
      pal_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      vram_we <= pop_p1 && (head_p1.region == REGION_VRAM);
      pal_we  <= pop_p1 && (head_p1.region == REGION_PAL);
      if (pop_p1) begin
        mem_waddr <= head_p1.waddr;
        mem_wdata <= head_p1.data;
        mem_be    <= head_p1.be;
      end
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: directed, table-driven bench for vram_writer plus
// hand-written sequences for back-pressure, DISPCNT sampling and reset.
module tb_vram_writer;

  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] K_DROP = 2'd0;
  localparam logic [1:0] K_VRAM = 2'd1;
  localparam logic [1:0] K_PAL  = 2'd2;

  typedef struct {
    logic        region;
    logic        size;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [2:0]  mode;
    logic [1:0]  kind;
    logic [15:0] exp_waddr;
    logic [15:0] exp_wdata;
  } vec_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dispcnt = 16'h0000;
  logic        disp_busy = 1'b0;
  logic        vram_we;
  logic        pal_we;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        fifo_empty;

  int passed = 0;
  int total  = 0;

  vec_t vecs [NV];

  vram_writer_if bus ();

  vram_writer #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (bus),
    .dispcnt    (dispcnt),
    .disp_busy  (disp_busy),
    .vram_we    (vram_we),
    .pal_we     (pal_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Presents one store for exactly one rising edge; returns at the falling
  // edge just after the acceptance edge.
  task automatic drive_store(input logic region, input logic size, input logic [16:0] addr,
                             input logic [15:0] wdata, input logic [2:0] mode);
    @(negedge clk);
    bus.cpu_region = region;
    bus.cpu_size   = size;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    dispcnt        = {13'h0000, mode};
    bus.cpu_req    = 1'b1;
    @(negedge clk);
    bus.cpu_req    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_we;
    logic [15:0] seq [5];
    int          got;
    int          first_cyc;
    int          last_cyc;
    logic        pending_drop;
    int          strobes;

    bus.cpu_req    = 1'b0;
    bus.cpu_region = 1'b0;
    bus.cpu_size   = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;

    // region, size, addr, wdata, mode, kind, exp_waddr, exp_wdata
    vecs[0]  = '{1'b0, 1'b1, 17'h00100, 16'h7FFF, 3'd0, K_VRAM, 16'h0080, 16'h7FFF};
    vecs[1]  = '{1'b1, 1'b0, 17'h00003, 16'hFF12, 3'd0, K_PAL,  16'h0001, 16'h1212};
    vecs[2]  = '{1'b0, 1'b0, 17'h14000, 16'h0033, 3'd3, K_DROP, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 17'h0FFFF, 16'h00AB, 3'd0, K_VRAM, 16'h7FFF, 16'hABAB};
    vecs[4]  = '{1'b0, 1'b0, 17'h13FFF, 16'h995C, 3'd3, K_VRAM, 16'h9FFF, 16'h5C5C};
    vecs[5]  = '{1'b0, 1'b0, 17'h10000, 16'h0011, 3'd0, K_DROP, 16'h0000, 16'h0000};
`ifdef VRAM_MIRROR_EN
    vecs[6]  = '{1'b0, 1'b1, 17'h18010, 16'h1234, 3'd0, K_VRAM, 16'h8008, 16'h1234};
    vecs[9]  = '{1'b0, 1'b0, 17'h1A000, 16'h0077, 3'd3, K_VRAM, 16'h9000, 16'h7777};
`else
    vecs[6]  = '{1'b0, 1'b1, 17'h18010, 16'h1234, 3'd0, K_DROP, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 17'h1A000, 16'h0077, 3'd3, K_DROP, 16'h0000, 16'h0000};
`endif
    vecs[7]  = '{1'b1, 1'b1, 17'h1E1FF, 16'hBEEF, 3'd0, K_PAL,  16'h00FF, 16'hBEEF};
    vecs[8]  = '{1'b0, 1'b1, 17'h00301, 16'hA5A5, 3'd0, K_VRAM, 16'h0180, 16'hA5A5};
    vecs[10] = '{1'b0, 1'b0, 17'h13FFF, 16'h0042, 3'd5, K_VRAM, 16'h9FFF, 16'h4242};
    vecs[11] = '{1'b0, 1'b1, 17'h17FFE, 16'h0F0F, 3'd0, K_VRAM, 16'hBFFF, 16'h0F0F};

    // Reset state, observed before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_vram_we",    vram_we,       1'b0);
    check("rst_pal_we",     pal_we,        1'b0);
    check("rst_waddr",      mem_waddr,     16'h0000);
    check("rst_wdata",      mem_wdata,     16'h0000);
    check("rst_be",         mem_be,        2'b00);
    check("rst_cpu_ready",  bus.cpu_ready, 1'b1);
    check("rst_fifo_empty", fifo_empty,    1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single stores, each drained with disp_busy low.
    for (int i = 0; i < NV; i++) begin
      exp_we = (vecs[i].kind == K_VRAM) ? 2'b10 :
               (vecs[i].kind == K_PAL)  ? 2'b01 : 2'b00;
      drive_store(vecs[i].region, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].mode);
      check($sformatf("v%0d_no_early_strobe", i), {vram_we, pal_we}, 2'b00);
      check($sformatf("v%0d_fifo_empty", i), fifo_empty, (vecs[i].kind == K_DROP));
      @(negedge clk);
      check($sformatf("v%0d_strobe", i), {vram_we, pal_we}, exp_we);
      if (vecs[i].kind != K_DROP) begin
        check($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].exp_waddr);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_be", i),    mem_be,    2'b11);
      end
      @(negedge clk);
      check($sformatf("v%0d_strobe_one_cycle", i), {vram_we, pal_we}, 2'b00);
      check($sformatf("v%0d_empty_after", i), fifo_empty, 1'b1);
      if (vecs[i].kind != K_DROP)
        check($sformatf("v%0d_waddr_hold", i), mem_waddr, vecs[i].exp_waddr);
    end

    // DISPCNT is taken at acceptance: mode 3 lets this byte through even
    // though the mode has dropped back to 0 by the time it drains.
    disp_busy = 1'b1;
    drive_store(1'b0, 1'b0, 17'h12000, 16'h0066, 3'd3);
    dispcnt = 16'h0000;
    @(negedge clk);
    check("mode_sample_held", fifo_empty, 1'b0);
    disp_busy = 1'b0;
    @(negedge clk);
    check("mode_sample_we",    vram_we,   1'b1);
    check("mode_sample_waddr", mem_waddr, 16'h9000);
    check("mode_sample_wdata", mem_wdata, 16'h6666);

    // Back-pressure: fill while the display holds the port, then release.
    disp_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      drive_store(1'b0, 1'b1, 17'h00200 + 17'(2 * i), 16'h1000 + 16'(i), 3'd0);
    check("full_ready_low",   bus.cpu_ready, 1'b0);
    check("full_not_empty",   fifo_empty,    1'b0);
    check("full_no_strobe",   {vram_we, pal_we}, 2'b00);
    bus.cpu_region = 1'b0;
    bus.cpu_size   = 1'b1;
    bus.cpu_addr   = 17'h00208;
    bus.cpu_wdata  = 16'h1004;
    bus.cpu_req    = 1'b1;
    disp_busy      = 1'b0;
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    pending_drop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pending_drop) begin
        bus.cpu_req  = 1'b0;
        pending_drop = 1'b0;
      end
      if (c == 0)
        check("full_pop_no_bypass_drain", vram_we, 1'b1);
      if (vram_we) begin
        if (got < 5) seq[got] = mem_waddr;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
      if (bus.cpu_req && bus.cpu_ready) pending_drop = 1'b1;
    end
    check("bp_strobe_count", got, 5);
    check("bp_back_to_back", last_cyc - first_cyc, 4);
    for (int i = 0; i < 5; i++)
      if (i < got) check($sformatf("bp_order%0d", i), seq[i], 16'h0100 + 16'(i));
    check("bp_empty_end", fifo_empty, 1'b1);
    check("bp_ready_end", bus.cpu_ready, 1'b1);

    // Reset with three stores pending discards them all.
    disp_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      drive_store(1'b0, 1'b1, 17'h00400 + 17'(2 * i), 16'h2000 + 16'(i), 3'd0);
    check("prerst_not_empty", fifo_empty, 1'b0);
    check("prerst_waddr",     mem_waddr,  16'h0104);
    #2 rst = 1'b1;
    #1;
    check("midrst_waddr",      mem_waddr,     16'h0000);
    check("midrst_wdata",      mem_wdata,     16'h0000);
    check("midrst_be",         mem_be,        2'b00);
    check("midrst_we",         {vram_we, pal_we}, 2'b00);
    check("midrst_fifo_empty", fifo_empty,    1'b1);
    check("midrst_cpu_ready",  bus.cpu_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    disp_busy = 1'b0;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vram_we || pal_we) strobes++;
    end
    check("postrst_no_strobe",  strobes,       0);
    check("postrst_fifo_empty", fifo_empty,    1'b1);
    check("postrst_cpu_ready",  bus.cpu_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
